// File: rtl/lab3_mem_pkg.sv
// Shared memory message definitions for the two-bank cache slice.
// Holds request/response structs, bank ID type and bank count.
package lab3_mem_pkg;

    localparam int c_num_banks = 2;

    typedef logic [0:0] bank_id_t;

    typedef enum logic [2:0] {
        c_mem_read  = 3'd0,
        c_mem_write = 3'd1,
        c_mem_init  = 3'd2
    } mem_type_t;

    typedef struct packed {
        mem_type_t   type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        mem_type_t   type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

endpackage

// File: rtl/lab3_mem_bank_order_queue.sv
// FIFO of bank IDs recording which bank owns each outstanding request.
// Ports: clk, reset (async low), push/push_id, pop, full, empty, head_id.
module lab3_mem_bank_order_queue
    import lab3_mem_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  bank_id_t push_id,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output bank_id_t head_id
);

    localparam int c_aw = $clog2(p_depth);
    localparam logic [c_aw:0] c_full_cnt = (c_aw + 1)'(p_depth);

    bank_id_t        entries [p_depth];
    logic [c_aw-1:0] head;
    logic [c_aw-1:0] tail;
    logic [c_aw:0]   count;

    assign full    = (count == c_full_cnt);
    assign empty   = (count == '0);
    assign head_id = entries[head];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while non-empty.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_id;
    end

endmodule

// File: rtl/lab3_mem_cache_bank_router.sv
// Steers processor requests to one of two cache banks by an address bit
// and returns bank responses in original request order.
// Ports: procreq/procresp (processor side), bankreq/bankresp (per bank).
module lab3_mem_cache_bank_router
    import lab3_mem_pkg::*;
#(
    parameter int p_bank_bit   = 4,
    parameter int p_ordq_depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   procreq_val,
    output logic                   procreq_rdy,
    input  mem_req_4B_t            procreq_msg,

    output logic                   procresp_val,
    input  logic                   procresp_rdy,
    output mem_resp_4B_t           procresp_msg,

    output logic [c_num_banks-1:0] bankreq_val,
    input  logic [c_num_banks-1:0] bankreq_rdy,
    output mem_req_4B_t            bankreq_msg0,
    output mem_req_4B_t            bankreq_msg1,

    input  logic [c_num_banks-1:0] bankresp_val,
    output logic [c_num_banks-1:0] bankresp_rdy,
    input  mem_resp_4B_t           bankresp_msg0,
    input  mem_resp_4B_t           bankresp_msg1
);

    bank_id_t req_bank;
    bank_id_t head_id;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;

    assign req_bank     = procreq_msg.addr[p_bank_bit];
    assign bankreq_msg0 = procreq_msg;
    assign bankreq_msg1 = procreq_msg;

    // Ready terms use only bank readiness and queue state, never the
    // matching valid, so no handshake loop forms through this stage.
    always_comb begin
        bankreq_val  = '0;
        bankresp_rdy = '0;
        procreq_rdy  = bankreq_rdy[req_bank] & ~full;
        bankreq_val[req_bank] = procreq_val & ~full;
        procresp_val = ~empty & bankresp_val[head_id];
        bankresp_rdy[head_id] = ~empty & procresp_rdy;
        procresp_msg = (head_id == 1'b1) ? bankresp_msg1 : bankresp_msg0;
    end

    assign push = procreq_val & procreq_rdy;
    assign pop  = procresp_val & procresp_rdy;

    lab3_mem_bank_order_queue #(
        .p_depth (p_ordq_depth)
    ) u_ordq (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (req_bank),
        .pop     (pop),
        .full    (full),
        .empty   (empty),
        .head_id (head_id)
    );

endmodule

// File: tb/tb_lab3_mem_cache_bank_router.sv
// Directed and random bench for the two-bank request router.
// Banks are modelled as per-bank response queues in the bench.
module tb_lab3_mem_cache_bank_router;
    import lab3_mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         procreq_val;
    logic         procreq_rdy;
    mem_req_4B_t  procreq_msg;
    logic         procresp_val;
    logic         procresp_rdy;
    mem_resp_4B_t procresp_msg;
    logic [1:0]   bankreq_val;
    logic [1:0]   bankreq_rdy;
    mem_req_4B_t  bankreq_msg0;
    mem_req_4B_t  bankreq_msg1;
    logic [1:0]   bankresp_val;
    logic [1:0]   bankresp_rdy;
    mem_resp_4B_t bankresp_msg0;
    mem_resp_4B_t bankresp_msg1;

    always #5 clk = ~clk;

    lab3_mem_cache_bank_router dut (
        .clk           (clk),
        .reset         (reset),
        .procreq_val   (procreq_val),
        .procreq_rdy   (procreq_rdy),
        .procreq_msg   (procreq_msg),
        .procresp_val  (procresp_val),
        .procresp_rdy  (procresp_rdy),
        .procresp_msg  (procresp_msg),
        .bankreq_val   (bankreq_val),
        .bankreq_rdy   (bankreq_rdy),
        .bankreq_msg0  (bankreq_msg0),
        .bankreq_msg1  (bankreq_msg1),
        .bankresp_val  (bankresp_val),
        .bankresp_rdy  (bankresp_rdy),
        .bankresp_msg0 (bankresp_msg0),
        .bankresp_msg1 (bankresp_msg1)
    );

    typedef struct {
        logic       b;
        logic [7:0] op;
    } ent_t;

    ent_t       ord[$];
    logic [7:0] bq0[$];
    logic [7:0] bq1[$];
    logic [1:0] ben;
    logic [7:0] next_op;
    int         n_checks = 0;
    int         n_fail   = 0;

    function automatic mem_resp_4B_t mk_resp(logic [7:0] op);
        mem_resp_4B_t r;
        r.type_  = c_mem_read;
        r.opaque = op;
        r.test   = 2'b01;
        r.len    = 2'b00;
        r.data   = 32'hC0DE_0000 | {24'h0, op};
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(logic v, logic [31:0] addr, logic wr);
        procreq_val        = v;
        procreq_msg.type_  = wr ? c_mem_write : c_mem_read;
        procreq_msg.opaque = next_op;
        procreq_msg.addr   = addr;
        procreq_msg.len    = 2'b00;
        procreq_msg.data   = $urandom;
    endtask

    // One cycle: drive bank responses, check against the model, then
    // advance the model by whatever handshakes the rules say fire.
    task automatic step(string tag);
        logic       b;
        logic       h;
        logic       full;
        logic       exp_rv;
        logic       req_fire;
        logic       resp_fire;
        logic [1:0] exp_bv;
        logic [1:0] exp_rr;
        int         hsz;
        bankresp_val[0] = ben[0] && (bq0.size() > 0);
        bankresp_val[1] = ben[1] && (bq1.size() > 0);
        bankresp_msg0   = (bq0.size() > 0) ? mk_resp(bq0[0]) : '0;
        bankresp_msg1   = (bq1.size() > 0) ? mk_resp(bq1[0]) : '0;
        #1;
        chk({tag, " count"}, 64'(dut.u_ordq.count), 64'(ord.size()));
        b    = procreq_msg.addr[4];
        full = (ord.size() == 4);
        exp_bv = 2'b00;
        if (procreq_val && !full) exp_bv[b] = 1'b1;
        chk({tag, " bankreq_val"}, 64'(bankreq_val), 64'(exp_bv));
        chk({tag, " procreq_rdy"}, 64'(procreq_rdy),
            64'(bankreq_rdy[b] && !full));
        chk({tag, " bankreq_msg1"}, 64'(bankreq_msg1), 64'(procreq_msg));
        exp_rv = 1'b0;
        exp_rr = 2'b00;
        h      = 1'b0;
        if (ord.size() > 0) begin
            h   = ord[0].b;
            hsz = h ? bq1.size() : bq0.size();
            exp_rv = ben[h] && (hsz > 0);
            exp_rr[h] = procresp_rdy;
        end
        chk({tag, " procresp_val"}, 64'(procresp_val), 64'(exp_rv));
        chk({tag, " bankresp_rdy"}, 64'(bankresp_rdy), 64'(exp_rr));
        if (exp_rv)
            chk({tag, " procresp_msg"}, 64'(procresp_msg),
                64'(mk_resp(ord[0].op)));
        req_fire  = procreq_val && bankreq_rdy[b] && !full;
        resp_fire = exp_rv && procresp_rdy;
        if (resp_fire) begin
            void'(ord.pop_front());
            if (h) void'(bq1.pop_front());
            else   void'(bq0.pop_front());
        end
        if (req_fire) begin
            ord.push_back('{b, procreq_msg.opaque});
            if (b) bq1.push_back(procreq_msg.opaque);
            else   bq0.push_back(procreq_msg.opaque);
            next_op = next_op + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        procreq_val = 1'b0;
        ben = 2'b11;
        procresp_rdy = 1'b1;
        for (int i = 0; i < 6; i++) step("drain");
    endtask

    logic [31:0] alt_addr [3] = '{32'h0, 32'h10, 32'h20};

    initial begin
        reset        = 1'b0;
        next_op      = 8'd0;
        ben          = 2'b00;
        bankreq_rdy  = 2'b00;
        procresp_rdy = 1'b0;
        bankresp_val = 2'b00;
        bankresp_msg0 = '0;
        bankresp_msg1 = '0;
        set_req(1'b0, 32'h0, 1'b0);
        #2;
        chk("reset count", 64'(dut.u_ordq.count), 64'd0);
        chk("reset bankreq_val", 64'(bankreq_val), 64'd0);
        chk("reset procreq_rdy", 64'(procreq_rdy), 64'd0);
        chk("reset procresp_val", 64'(procresp_val), 64'd0);
        chk("reset bankresp_rdy", 64'(bankresp_rdy), 64'd0);
        #6;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Steering: 0x0 -> bank 0, 0x10 -> bank 1, in-order delivery.
        bankreq_rdy  = 2'b11;
        procresp_rdy = 1'b1;
        set_req(1'b1, 32'h0000_0000, 1'b0);
        step("steer req0");
        set_req(1'b1, 32'h0000_0010, 1'b0);
        step("steer req1");
        procreq_val = 1'b0;
        ben = 2'b11;
        step("steer resp0");
        step("steer resp1");
        step("steer idle");

        // Reordering: bank 1 ready first must wait behind bank 0.
        ben = 2'b00;
        set_req(1'b1, 32'h0000_0000, 1'b0);
        step("reord req0");
        set_req(1'b1, 32'h0000_0010, 1'b0);
        step("reord req1");
        procreq_val = 1'b0;
        ben = 2'b10;
        step("reord b1 early");
        ben = 2'b11;
        step("reord resp0");
        step("reord resp1");

        // Full: four outstanding blocks the fifth until one pops.
        ben = 2'b00;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, 32'(i) << 4, 1'b1);
            step("full fill");
        end
        set_req(1'b1, 32'h0000_0040, 1'b0);
        step("full blocked");
        ben = 2'b01;
        step("full pop");
        ben = 2'b00;
        step("full accept");
        procreq_val = 1'b0;
        step("full count4");
        drain();

        // Same-cycle push and pop at count 2 across pointer wrap.
        ben = 2'b00;
        set_req(1'b1, 32'h0, 1'b0);
        step("pp pre0");
        set_req(1'b1, 32'h10, 1'b0);
        step("pp pre1");
        ben = 2'b11;
        for (int i = 0; i < 10; i++) begin
            set_req(1'b1, alt_addr[i % 3], 1'b0);
            step("pushpop");
        end
        drain();

        // Backpressure: response held while procresp_rdy is low.
        ben = 2'b00;
        set_req(1'b1, 32'h0, 1'b0);
        step("bp req");
        procreq_val  = 1'b0;
        ben          = 2'b01;
        procresp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) step("bp hold");
        procresp_rdy = 1'b1;
        step("bp deliver");
        step("bp empty");

        // Reset with three requests outstanding.
        ben = 2'b00;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 32'(i) << 4, 1'b0);
            step("rst fill");
        end
        procreq_val   = 1'b0;
        bankresp_val  = 2'b11;
        bankresp_msg0 = mk_resp(8'hEE);
        bankresp_msg1 = mk_resp(8'hEF);
        reset = 1'b0;
        #1;
        chk("midrst count", 64'(dut.u_ordq.count), 64'd0);
        chk("midrst procresp_val", 64'(procresp_val), 64'd0);
        chk("midrst bankresp_rdy", 64'(bankresp_rdy), 64'd0);
        chk("midrst bankreq_val", 64'(bankreq_val), 64'd0);
        ord.delete();
        bq0.delete();
        bq1.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        set_req(1'b1, 32'h0000_0010, 1'b1);
        step("post-rst write");
        drain();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_req(1'($urandom), $urandom, 1'($urandom));
            bankreq_rdy  = 2'($urandom);
            ben          = 2'($urandom);
            procresp_rdy = ($urandom_range(0, 3) != 0);
            step("rand");
        end
        drain();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
